// File: rtl/video_timing_analyzer.sv
// ---------------------------------------------------------------------------
// video_timing_analyzer
//
// Sink-side companion of the video timing generator. Samples a raster stream
// on pixel-enable cycles, recovers active-video coordinates and a registered
// data enable, measures the raster geometry and reports lock once two
// consecutive frames have identical totals.
//
// Ports
//   clk, reset    system clock, synchronous active-high reset
//   ce_pix        pixel enable; video inputs are only looked at when high
//   hblank/hsync  horizontal blank (high = blanked) / sync (active high)
//   vblank/vsync  vertical blank (high = blanked) / sync (active high)
//   de, x, y      registered active-video enable and active coordinates
//   frame_start   one-clk pulse on each sampled VSync rising edge
//   h_total       ce cycles between the last two HSync rises
//   h_active      ce cycles with hblank low in the last completed line
//   v_total       HSync rises in the last completed frame
//   v_active      HSync rises with vblank low in the last completed frame
//   locked        totals stable over two consecutive frames
//
// Handshake: there is no backpressure. Every output is valid from the clk
// edge of the ce_pix cycle that produced it and holds until the next ce_pix
// cycle; frame_start alone is a single-clk strobe.
//
// The lock FSM state is kept in the named signal 'state' (type state_t) so
// it can be observed hierarchically.
// ---------------------------------------------------------------------------
module video_timing_analyzer #(
  parameter int CW      = 10,
  parameter int TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce_pix,
  input  logic          hblank,
  input  logic          hsync,
  input  logic          vblank,
  input  logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          frame_start,
  output logic [CW-1:0] h_total,
  output logic [CW-1:0] h_active,
  output logic [CW-1:0] v_total,
  output logic [CW-1:0] v_active,
  output logic          locked
);

  localparam logic [CW-1:0] CMAX  = '1;
  localparam logic [CW-1:0] ONE   = CW'(1);
  // Timeout fires on the ce cycle where pc would step onto TIMEOUT.
  localparam logic [CW-1:0] TO_M1 = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_SEARCH  = 2'd0,
    S_MEASURE = 2'd1,
    S_VERIFY  = 2'd2,
    S_LOCKED  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;

  logic          hs_prev;
  logic          vs_prev;
  logic          hb_prev;
  logic [CW-1:0] pc;        // ce cycles since last HSync rise
  logic [CW-1:0] ac;        // active ce cycles since last HSync rise
  logic [CW-1:0] lc;        // HSync rises since last VSync rise
  logic [CW-1:0] la;        // active HSync rises since last VSync rise
  logic          y_started; // first active line of the frame already seen
  logic [CW-1:0] cand_h;
  logic [CW-1:0] cand_v;
  logic [CW-1:0] cand_h_next;
  logic [CW-1:0] cand_v_next;

  logic          hs_rise;
  logic          vs_rise;
  logic          hb_fall;
  logic          timeout_hit;
  logic [CW-1:0] h_new;
  logic [CW-1:0] v_new;
  logic          mismatch;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CMAX) ? v : v + ONE;
  endfunction

  // Edges only exist on ce cycles; prev registers also move only on ce.
  assign hs_rise = ce_pix & hsync & ~hs_prev;
  assign vs_rise = ce_pix & vsync & ~vs_prev;
  assign hb_fall = ce_pix & ~hblank & hb_prev;

  // pc is about to reach TIMEOUT with no HSync rise to clear it.
  assign timeout_hit = ce_pix & ~hs_rise & (pc == TO_M1);

  // Totals as they will be after this cycle; the FSM compares these so a
  // line closing in the same cycle as the frame is already included.
  assign h_new    = hs_rise ? sat_inc(pc) : h_total;
  assign v_new    = lc;
  // A frame whose line count saturated never counts as a match.
  assign mismatch = (h_new != cand_h) | (v_new != cand_v) | (lc == CMAX);

  assign locked = (state == S_LOCKED);

  // -------------------------------------------------------------------------
  // Lock FSM: next state and candidate totals
  // -------------------------------------------------------------------------
  always_comb begin
    state_next  = state;
    cand_h_next = cand_h;
    cand_v_next = cand_v;
    if (timeout_hit) begin
      state_next = S_SEARCH;
    end else if (vs_rise) begin
      case (state)
        S_SEARCH: state_next = S_MEASURE;
        S_MEASURE: begin
          cand_h_next = h_new;
          cand_v_next = v_new;
          state_next  = S_VERIFY;
        end
        S_VERIFY: begin
          if (mismatch) begin
            cand_h_next = h_new;
            cand_v_next = v_new;
          end else begin
            state_next = S_LOCKED;
          end
        end
        S_LOCKED: begin
          if (mismatch) begin
            cand_h_next = h_new;
            cand_v_next = v_new;
            state_next  = S_VERIFY;
          end
        end
        default: state_next = S_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_SEARCH;
      cand_h <= '0;
      cand_v <= '0;
    end else begin
      state  <= state_next;
      cand_h <= cand_h_next;
      cand_v <= cand_v_next;
    end
  end

  // -------------------------------------------------------------------------
  // Measurement counters and latched totals
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_prev     <= 1'b0;
      vs_prev     <= 1'b0;
      hb_prev     <= 1'b0;
      pc          <= '0;
      ac          <= '0;
      lc          <= '0;
      la          <= '0;
      h_total     <= '0;
      h_active    <= '0;
      v_total     <= '0;
      v_active    <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= vs_rise;
      if (ce_pix) begin
        hs_prev <= hsync;
        vs_prev <= vsync;
        hb_prev <= hblank;

        // Horizontal measurement: the rising HSync sample closes the line.
        if (hs_rise) begin
          h_total  <= sat_inc(pc);
          h_active <= hblank ? ac : sat_inc(ac);
          pc       <= '0;
          ac       <= '0;
        end else begin
          pc <= sat_inc(pc);
          if (!hblank) begin
            ac <= sat_inc(ac);
          end
        end

        // Vertical measurement: a line starting together with VSync is the
        // first line of the new frame.
        if (vs_rise) begin
          v_total  <= lc;
          v_active <= la;
          lc       <= hs_rise ? ONE : '0;
          la       <= (hs_rise && !vblank) ? ONE : '0;
        end else if (hs_rise) begin
          lc <= sat_inc(lc);
          if (!vblank) begin
            la <= sat_inc(la);
          end
        end

        // Loss of HSync invalidates everything measured so far.
        if (timeout_hit) begin
          h_total  <= '0;
          h_active <= '0;
          v_total  <= '0;
          v_active <= '0;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Data enable and active coordinates
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      de        <= 1'b0;
      x         <= '0;
      y         <= '0;
      y_started <= 1'b0;
    end else if (ce_pix) begin
      de <= ~hblank & ~vblank;

      // x advances only after a pixel that was itself active, so the first
      // active pixel of a line reports 0.
      if (hblank) begin
        x <= '0;
      end else if (de) begin
        x <= sat_inc(x);
      end

      // y steps at each active line start; the first one of a frame is 0.
      if (vblank) begin
        y         <= '0;
        y_started <= 1'b0;
      end else if (hb_fall) begin
        if (y_started) begin
          y <= sat_inc(y);
        end else begin
          y         <= '0;
          y_started <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_video_timing_analyzer.sv
// ---------------------------------------------------------------------------
// tb_video_timing_analyzer
//
// Drives generated raster streams (fixed NTSC-like and PAL-like geometries
// scaled down in size, plus random geometries) with randomly spaced ce_pix
// and random hsync/vsync/blank noise on non-ce clocks. Expected values come
// from the raster description: line/frame structure, per-frame totals and a
// frame-history lock rule. A monitor pops and compares on every output event.
// ---------------------------------------------------------------------------
module tb_video_timing_analyzer;

  localparam int CW      = 10;
  localparam int TIMEOUT = 1023;
  localparam int CMAXI   = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          ce_pix;
  logic          hblank;
  logic          hsync;
  logic          vblank;
  logic          vsync;
  logic          de;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          frame_start;
  logic [CW-1:0] h_total;
  logic [CW-1:0] h_active;
  logic [CW-1:0] v_total;
  logic [CW-1:0] v_active;
  logic          locked;

  video_timing_analyzer #(.CW(CW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .ce_pix(ce_pix),
    .hblank(hblank), .hsync(hsync), .vblank(vblank), .vsync(vsync),
    .de(de), .x(x), .y(y), .frame_start(frame_start),
    .h_total(h_total), .h_active(h_active),
    .v_total(v_total), .v_active(v_active), .locked(locked)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [4*CW:0]   fs_q[$];     // {locked, h_total, h_active, v_total, v_active}
  logic [2*CW:0]   coord_q[$];  // {de, x, y}
  bit              mon_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  typedef struct {
    int hl;        // ce samples per line
    int hs_w;      // hsync width from line start
    int hb_start;  // first active sample
    int ha;        // active samples per line
    int nl;        // lines per frame
    int va;        // active lines (0..va-1)
  } geom_t;

  int  since_rise;   // ce samples after the last HSync rise (or reset)
  int  act_since;    // active samples after the last HSync rise
  int  lines_cnt;    // line starts since the last VSync rise
  int  act_lines;    // active line starts since the last VSync rise
  int  vs_k;         // VSync rises since reset / timeout
  int  cur_h, cur_ha;
  int  prev_h, prev_v;
  bit  model_locked;

  task automatic model_reset();
    since_rise   = 0;
    act_since    = 0;
    lines_cnt    = 0;
    act_lines    = 0;
    vs_k         = 0;
    cur_h        = 0;
    cur_ha       = 0;
    prev_h       = -1;
    prev_v       = -1;
    model_locked = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    ce_pix = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_de", de, 0);
    chk("reset_x", x, 0);
    chk("reset_y", y, 0);
    chk("reset_frame_start", frame_start, 0);
    chk("reset_h_total", h_total, 0);
    chk("reset_h_active", h_active, 0);
    chk("reset_v_total", v_total, 0);
    chk("reset_v_active", v_active, 0);
    chk("reset_locked", locked, 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // One ce sample, preceded by 0..1 noisy non-ce clocks.
  task automatic drive(input logic hs, input logic hb, input logic vs, input logic vb,
                       input bit hrise, input bit vrise, input int xe, input int ye);
    int gap;
    bit tmo;
    int h_e, v_e, va_e;
    logic [CW-1:0] xv, yv;
    gap = $urandom_range(0, 1);
    repeat (gap) begin
      @(negedge clk);
      ce_pix = 1'b0;
      hsync  = 1'($urandom_range(0, 1));
      vsync  = 1'($urandom_range(0, 1));
      hblank = 1'($urandom_range(0, 1));
      vblank = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    ce_pix = 1'b1;
    hsync  = hs;
    hblank = hb;
    vsync  = vs;
    vblank = vb;

    xv = xe[CW-1:0];
    yv = ye[CW-1:0];
    coord_q.push_back({(~hb & ~vb), xv, yv});

    tmo = 1'b0;
    if (hrise) begin
      h_e        = (since_rise + 1 > CMAXI) ? CMAXI : since_rise + 1;
      cur_h      = h_e;
      cur_ha     = act_since + (hb ? 0 : 1);
      since_rise = 0;
      act_since  = 0;
    end else begin
      since_rise++;
      if (!hb) act_since++;
      if (since_rise == TIMEOUT) tmo = 1'b1;
    end

    if (vrise) begin
      v_e  = lines_cnt;
      va_e = act_lines;
      vs_k++;
      // Locked once at least three frame marks seen and the latest two
      // frames share their totals.
      model_locked = (vs_k >= 3) && (cur_h == prev_h) && (v_e == prev_v);
      prev_h = cur_h;
      prev_v = v_e;
      fs_q.push_back({model_locked, cur_h[CW-1:0], cur_ha[CW-1:0],
                      v_e[CW-1:0], va_e[CW-1:0]});
      lines_cnt = hrise ? 1 : 0;
      act_lines = (hrise && !vb) ? 1 : 0;
    end else if (hrise) begin
      lines_cnt++;
      if (!vb) act_lines++;
    end

    if (tmo) begin
      vs_k         = 0;
      cur_h        = 0;
      cur_ha       = 0;
      model_locked = 1'b0;
      @(posedge clk);
      #1;
      chk("timeout_locked", locked, 0);
      chk("timeout_h_total", h_total, 0);
      chk("timeout_h_active", h_active, 0);
      chk("timeout_v_total", v_total, 0);
      chk("timeout_v_active", v_active, 0);
    end
  endtask

  // One full frame of the given geometry; optional reset before one sample.
  task automatic run_frame(input geom_t g, input int rst_line, input int rst_p);
    logic hs, hb, vs, vb;
    int xe, ye;
    for (int l = 0; l < g.nl; l++) begin
      for (int p = 0; p < g.hl; p++) begin
        if (l == rst_line && p == rst_p) do_reset();
        hs = (p < g.hs_w);
        hb = !(p >= g.hb_start && p < g.hb_start + g.ha);
        vb = (l >= g.va);
        vs = (l >= g.nl - 3);
        xe = (!hb && !vb) ? p - g.hb_start : 0;
        if (vb) ye = 0;
        else if (p < g.hb_start) ye = (l == 0) ? 0 : l - 1;
        else ye = l;
        drive(hs, hb, vs, vb, (p == 0), (p == 0 && l == g.nl - 3), xe, ye);
      end
    end
  endtask

  // ---------------- monitor ----------------
  logic          ce_d;
  logic          rst_d;
  logic [63:0]   snap;

  always @(posedge clk) begin
    ce_d  <= ce_pix;
    rst_d <= reset;
  end

  always @(negedge clk) begin
    logic [63:0]   cur;
    logic [2*CW:0] ce_exp;
    logic [4*CW:0] fs_exp;
    cur = {2'b00, de, x, y, h_total, h_active, v_total, v_active, locked};
    if (mon_en) begin
      if (ce_d && !rst_d) begin
        if (coord_q.size() == 0) begin
          chk("coord_queue_underflow", 1, 0);
        end else begin
          ce_exp = coord_q.pop_front();
          chk("de", de, ce_exp[2*CW]);
          chk("x", x, ce_exp[2*CW-1:CW]);
          chk("y", y, ce_exp[CW-1:0]);
        end
      end else if (!rst_d) begin
        chk("hold_outputs", cur, snap);
        chk("hold_frame_start", frame_start, 0);
      end
      if (frame_start) begin
        if (fs_q.size() == 0) begin
          chk("frame_start_unexpected", 1, 0);
        end else begin
          fs_exp = fs_q.pop_front();
          chk("fs_locked", locked, fs_exp[4*CW]);
          chk("fs_h_total", h_total, fs_exp[4*CW-1:3*CW]);
          chk("fs_h_active", h_active, fs_exp[3*CW-1:2*CW]);
          chk("fs_v_total", v_total, fs_exp[2*CW-1:CW]);
          chk("fs_v_active", v_active, fs_exp[CW-1:0]);
        end
      end
    end
    snap = cur;
  end

  // ---------------- stimulus ----------------
  initial begin
    geom_t g_ntsc, g_pal, g_rnd;
    reset  = 1'b0;
    ce_pix = 1'b0;
    hsync  = 1'b0;
    vsync  = 1'b0;
    hblank = 1'b1;
    vblank = 1'b1;
    g_ntsc = '{hl: 40, hs_w: 4, hb_start: 6, ha: 30, nl: 20, va: 15};
    g_pal  = '{hl: 40, hs_w: 4, hb_start: 6, ha: 30, nl: 24, va: 18};

    do_reset();
    mon_en = 1'b1;

    // Lock on NTSC-like raster: lock expected at the 3rd VSync rise.
    repeat (4) run_frame(g_ntsc, -1, -1);
    chk("locked_after_ntsc", locked, 1);

    // Line-count change: lock drops, then returns one frame later.
    repeat (3) run_frame(g_pal, -1, -1);
    chk("locked_after_pal", locked, 1);

    // Random geometries.
    repeat (2) begin
      g_rnd.hl       = $urandom_range(24, 48);
      g_rnd.hs_w     = $urandom_range(2, 4);
      g_rnd.hb_start = g_rnd.hs_w + $urandom_range(1, 3);
      g_rnd.ha       = $urandom_range(8, g_rnd.hl - g_rnd.hb_start - 1);
      g_rnd.nl       = $urandom_range(12, 24);
      g_rnd.va       = $urandom_range(4, g_rnd.nl - 5);
      repeat (3) run_frame(g_rnd, -1, -1);
      chk("locked_random", locked, model_locked);
    end

    // Lose HSync while locked.
    repeat (3) run_frame(g_ntsc, -1, -1);
    chk("locked_before_hold", locked, 1);
    for (int i = 0; i < TIMEOUT + 20; i++) drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    chk("locked_after_hold", locked, 0);
    repeat (4) run_frame(g_ntsc, -1, -1);
    chk("relocked_after_timeout", locked, 1);

    // Reset mid-line while locked, then relock.
    run_frame(g_ntsc, g_ntsc.va + 1, g_ntsc.hl / 2);
    repeat (4) run_frame(g_ntsc, -1, -1);
    chk("relocked_after_reset", locked, 1);

    @(negedge clk);
    ce_pix = 1'b0;
    repeat (4) @(negedge clk);
    chk("fs_queue_drained", fs_q.size(), 0);
    chk("coord_queue_drained", coord_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/video_timing_analyzer.md
Name: video_timing_analyzer

Overview:
- Sink-side counterpart of the core's video timing generator.
- Samples a raster stream (ce_pix, HSync, VSync, HBlank, VBlank) and recovers per-pixel active coordinates and a data-enable.
- Measures line length, active width, lines per frame and active lines, and reports lock once two consecutive frames match.
- Sits between the timing generator / video mixer and downstream consumers: framebuffer writer, OSD overlay, format checks.

Parameters:
- CW, 10, width of all pixel/line counters and measured totals.
- TIMEOUT, 1023, ce_pix cycles without an HSync rising edge before lock is dropped; must be ≤ 2^CW-1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ce_pix  in  1  pixel enable; all video inputs are sampled only when ce_pix=1
- hblank  in  1  horizontal blank, high = blanked
- hsync  in  1  horizontal sync, active high
- vblank  in  1  vertical blank, high = blanked
- vsync  in  1  vertical sync, active high
- de  out  1  active-video enable, registered
- x  out  CW  active pixel index within the line
- y  out  CW  active line index within the frame
- frame_start  out  1  one-clk pulse on each VSync rising edge
- h_total  out  CW  ce cycles between the last two HSync rises
- h_active  out  CW  ce cycles with hblank=0 in the last completed line
- v_total  out  CW  HSync rises in the last completed frame
- v_active  out  CW  HSync rises with vblank=0 in the last completed frame
- locked  out  1  timing stable over two consecutive frames

Behaviour:
- Reset: all outputs 0; previous-sample registers 0; state SEARCH; all counters 0. Reset wins over every other event, including mid-frame.
- Edge detection: prev registers for hsync and vsync update only on ce_pix cycles. A rise is sampled=1 and prev=0 on a ce_pix cycle. No edge is ever detected on a non-ce cycle.
- Outputs update on the clk edge of the ce cycle that produced them (1-clk latency). Between ce cycles all outputs hold, except frame_start, which is a 1-clk pulse.
- Pixel counter pc:
  - Increments each ce cycle, saturating at 2^CW-1.
  - On an HSync rise: h_total <= pc+1, then pc <= 0.
- Active width counter ac:
  - Increments on ce cycles with hblank=0, saturating.
  - On an HSync rise: h_active <= ac + (hblank==0 ? 1 : 0), then ac <= 0.
- Line counters:
  - lc increments on each HSync rise.
  - la increments on each HSync rise where vblank=0.
- On a VSync rise:
  - Latch v_total <= lc and v_active <= la.
  - If an HSync rise occurs in the same ce cycle, that line belongs to the new frame: lc <= 1, la <= (vblank==0). Otherwise lc <= 0, la <= 0.
  - frame_start=1 for exactly one clk.
- de/x/y:
  - de <= ~hblank & ~vblank on each ce cycle.
  - x: 0 while hblank=1; otherwise x <= x+1 after each de cycle, so the first active pixel reports x=0.
  - y: 0 while vblank=1; increments by 1 on each hblank falling edge (sampled) with vblank=0, except the first active line, which is y=0.
  - x and y saturate at 2^CW-1.
- Lock state machine, evaluated at VSync rise unless noted:
  - SEARCH: first VSync rise -> MEASURE. locked=0.
  - MEASURE: next VSync rise -> store candidate (h_total, v_total) -> VERIFY.
  - VERIFY: VSync rise with new totals equal to candidate -> LOCKED, locked=1. If unequal: candidate <= new totals, stay in VERIFY.
  - LOCKED: totals differ from candidate -> VERIFY, locked=0 in the same clk, candidate updated.
- Timeout: pc reaching TIMEOUT in any state -> SEARCH. Same clk: locked=0, h_total=h_active=v_total=v_active=0.
- Frames with lc saturated are treated as mismatched.

Test Plan:
- Generator-like NTSC stimulus (ce every 2nd clk; 638-cycle lines, hblank low 530 cycles, hsync high 46 cycles; 262 lines, vblank low 240 lines, vsync rise coincident with hsync rise), 4 frames:
  - h_total=638, h_active=530, v_total=262, v_active=240.
  - locked rises at the 3rd VSync rise.
  - frame_start is exactly 4 one-clk pulses.
- Same stream, check coordinates: de high exactly 530×240 ce cycles per frame; max x=529, max y=239; x=0 and y=0 on the first active pixel.
- PAL switch (312 lines) after lock: locked drops at the first 312-line VSync rise and re-asserts one frame later with v_total=312.
- Hold hsync low for 1023 ce cycles while locked: locked=0 and all totals 0 on the timeout clk; relock requires 3 VSync rises.
- Assert reset mid-line while locked: next clk all outputs 0 and state SEARCH; the stream resumes and locks after 3 VSync rises.
- Toggle hsync on non-ce clks only: no count, edge or output change.
